blur_frame_writer: RTL and testbench
====================================

Name: blur_frame_writer

Overview:
- Sink end of the Gaussian blur pixel stream: accepts the filter's `le`/`o_data` output and writes each valid pixel into a linear frame buffer.
- Buffers pixels in a small FIFO to absorb frame-buffer backpressure.
- Generates sequential write addresses and signals frame completion to the display/capture controller.

Parameters:
- IMG_WIDTH, 640, input image width; output width OUT_W = IMG_WIDTH-2
- IMG_HEIGHT, 480, input image height; output height OUT_H = IMG_HEIGHT-2
- FIFO_DEPTH, 8, pixel FIFO entries (power of two, ≥2)
- ADDR_W, 19, frame-buffer address width; must hold OUT_W*OUT_H-1

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- frame_start  in  1  one-cycle pulse; arms or restarts frame capture
- le  in  1  filtered pixel valid (one pixel per cycle when high)
- i_data  in  12  filtered pixel, {R,G,B} 4 bits each
- mem_ready  in  1  frame buffer accepts the current write this cycle
- mem_we  out  1  write request
- mem_addr  out  ADDR_W  write address, 0 .. OUT_W*OUT_H-1
- mem_wdata  out  12  write data, equal to the FIFO head
- frame_done  out  1  one-cycle pulse after the last pixel of the frame is written
- overflow  out  1  sticky: a pixel was dropped because the FIFO was full
- busy  out  1  high in WRITE state

Behaviour:
- Reset: clk edge with reset=0 sets state IDLE, FIFO empty, all counters 0. All outputs read 0 (mem_we, mem_addr, mem_wdata, frame_done, overflow, busy).
- Constants: TOTAL = OUT_W*OUT_H.
- FSM states IDLE, WRITE, DONE.
  - IDLE: le is ignored. frame_start → WRITE; clears push_cnt, addr, overflow, FIFO.
  - WRITE: busy=1.
    - Push: le=1 and push_cnt<TOTAL.
      - If the FIFO is not full, or a pop occurs the same cycle, the push is accepted and push_cnt++.
      - Otherwise the pixel is dropped, overflow←1, and push_cnt still increments so the frame stays aligned.
    - le with push_cnt==TOTAL is ignored; this does not count as overflow.
    - Pop: mem_we = FIFO not empty. A write completes when mem_we && mem_ready; then the FIFO pops and addr++.
    - Transition: when the completed write is at addr==TOTAL-1 → DONE.
    - Dropped pixels leave holes. When push_cnt reaches TOTAL and the FIFO is empty with addr<TOTAL (overflow=1), go → DONE.
  - DONE: frame_done=1 for exactly this one cycle, then → IDLE. mem_we=0.
- frame_start in WRITE or DONE: abort. Flush the FIFO, clear push_cnt/addr/overflow, enter WRITE next cycle. frame_done is not pulsed for the aborted frame.
- Latency: le at cycle N with the FIFO empty → mem_we=1 with that pixel at N+1. With mem_ready held 1, throughput is 1 pixel/cycle.
- mem_addr/mem_wdata are stable while mem_we=1 and mem_ready=0.
- Simultaneous push and pop with the FIFO full: both take effect and the count is unchanged.
- Simultaneous push and pop with the FIFO empty: the push is stored; no pop occurs (mem_we was 0).
- Address arithmetic: incremental counter only, no multiplier. Wraps never occur because the transition happens at TOTAL-1.
- reset=0 at any point overrides all state, including mid-write.

Decomposition:
- Package blur_pkg:
  - IMG_WIDTH, IMG_HEIGHT, derived OUT_W/OUT_H/TOTAL
  - typedef enum logic [1:0] {IDLE, WRITE, DONE} wr_state_t
  - typedef logic [11:0] rgb444_t
- Sub-module sync_fifo:
  - Parameterised width/depth, full/empty flags.
  - Same-cycle push-when-full-with-pop supported; synchronous active-low reset and flush input.

Test Plan:
- Config IMG_WIDTH=6, IMG_HEIGHT=5 (TOTAL=12). Reset then idle with le=1 → mem_we stays 0 and busy=0.
- frame_start, then 12 consecutive le with i_data=0x000..0x00B, mem_ready=1:
  - mem_we trails le by 1 cycle; addr 0..11 carries data 0x000..0x00B.
  - frame_done pulses once; overflow=0.
- Same stream with mem_ready=0 for cycles 2–20 of the frame:
  - FIFO fills 8, four pixels are dropped, overflow=1.
  - Written data: 0x000..0x007 at addr 0..7.
  - Terminates via the drained-with-holes path, then a frame_done pulse.
- mem_ready toggling 1/0 every cycle with 12 pixels spaced every 2 cycles → no overflow; all 12 writes complete in order.
- frame_start asserted after 5 pixels → FIFO flushed, addr restarts at 0, no frame_done until 12 new pixels are written.
- Assert reset=0 during the write at addr=6 → next cycle all outputs are 0, state IDLE. A subsequent frame completes normally.

Source files
------------

// File: rtl/blur_pkg.sv
// Shared definitions for the blur output path.
// Holds the default image geometry and the frame-size helper, the writer
// FSM state type and the 12-bit {R,G,B} pixel type.
package blur_pkg;

  localparam int IMG_WIDTH  = 640;
  localparam int IMG_HEIGHT = 480;
  localparam int OUT_W      = IMG_WIDTH - 2;
  localparam int OUT_H      = IMG_HEIGHT - 2;
  localparam int TOTAL      = OUT_W * OUT_H;
  localparam int FIFO_DEPTH = 8;
  localparam int ADDR_W     = 19;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} wr_state_t;
  typedef logic [11:0] rgb444_t;

  // The 3x3 filter trims one pixel from every edge.
  function automatic int frame_total(input int width, input int height);
    return (width - 2) * (height - 2);
  endfunction

endpackage

// File: rtl/blur_frame_writer_sync_fifo.sv
// Synchronous FIFO used to absorb frame-buffer backpressure.
// Ports:
//   clk, reset (sync, active-low), flush (sync clear)
//   push/wdata : write side; accepted when not full, or when full with a pop
//   pop/rdata  : read side; rdata is the head entry (show-ahead)
//   full/empty : occupancy flags
module sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // When full, the slot being written is the one the pop frees this cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_q <= count_q + (PTR_W+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (PTR_W+1)'(1);
    end
  end

  // Storage is not reset; the consumer gates rdata with its own valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/blur_frame_writer.sv
// Sink end of the blur pixel stream: writes every valid filtered pixel to a
// linear frame buffer at sequential addresses and pulses frame_done when the
// frame has been written.
// Ports:
//   clk, reset (sync, active-low)
//   frame_start      : pulse, arms capture or restarts the current frame
//   le, i_data       : filtered pixel stream
//   mem_ready        : frame buffer accepts the current write
//   mem_we/addr/wdata: write request, address and data (FIFO head)
//   frame_done       : one-cycle pulse after the last write of a frame
//   overflow         : sticky, a pixel was dropped on a full FIFO
//   busy             : capture in progress
//
// state | meaning
// IDLE  | waiting for frame_start, le ignored
// WRITE | accepting pixels and draining the FIFO to memory
// DONE  | frame_done pulse, returns to IDLE
module blur_frame_writer #(
  parameter int IMG_WIDTH  = blur_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT = blur_pkg::IMG_HEIGHT,
  parameter int FIFO_DEPTH = blur_pkg::FIFO_DEPTH,
  parameter int ADDR_W     = blur_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              le,
  input  logic [11:0]       i_data,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [11:0]       mem_wdata,
  output logic              frame_done,
  output logic              overflow,
  output logic              busy
);

  import blur_pkg::*;

  localparam int FRAME_TOTAL = frame_total(IMG_WIDTH, IMG_HEIGHT);
  localparam int CNT_W       = $clog2(FRAME_TOTAL + 1);

  wr_state_t         state_q, state_d;
  logic [CNT_W-1:0]  push_cnt_q, push_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              overflow_q, overflow_d;

  logic    fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic    push_req, wr_done, frame_in;
  rgb444_t fifo_rdata;

  sync_fifo #(
    .WIDTH (12),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (fifo_flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (i_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign busy       = (state_q == WRITE);
  assign mem_we     = busy && !fifo_empty;
  assign mem_addr   = addr_q;
  assign mem_wdata  = mem_we ? fifo_rdata : 12'h000;
  assign frame_done = (state_q == DONE);
  assign overflow   = overflow_q;

  always_comb begin
    state_d    = state_q;
    push_cnt_d = push_cnt_q;
    addr_d     = addr_q;
    overflow_d = overflow_q;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    wr_done    = 1'b0;
    push_req   = 1'b0;
    frame_in   = (push_cnt_q == CNT_W'(FRAME_TOTAL));

    if (frame_start) begin
      // Start and abort are the same action from any state.
      state_d    = WRITE;
      push_cnt_d = '0;
      addr_d     = '0;
      overflow_d = 1'b0;
      fifo_flush = 1'b1;
    end else begin
      case (state_q)
        WRITE: begin
          wr_done  = mem_we && mem_ready;
          fifo_pop = wr_done;
          push_req = le && !frame_in;
          if (push_req) begin
            // A dropped pixel still counts, keeping the frame aligned.
            push_cnt_d = push_cnt_q + CNT_W'(1);
            if (!fifo_full || wr_done) fifo_push  = 1'b1;
            else                       overflow_d = 1'b1;
          end
          if (wr_done && addr_q == ADDR_W'(FRAME_TOTAL - 1)) begin
            state_d = DONE;
          end else begin
            if (wr_done) addr_d = addr_q + ADDR_W'(1);
            // All pixels seen and drained short of the last address:
            // only reachable when drops left holes.
            if (frame_in && fifo_empty) state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      push_cnt_q <= '0;
      addr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      push_cnt_q <= push_cnt_d;
      addr_q     <= addr_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_blur_frame_writer.sv
module tb_blur_frame_writer;

  localparam int W     = 6;
  localparam int H     = 5;
  localparam int DEPTH = 8;
  localparam int AW    = 19;
  localparam int TOTAL = (W - 2) * (H - 2);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          frame_start = 1'b0;
  logic          le = 1'b0;
  logic [11:0]   i_data = 12'h000;
  logic          mem_ready = 1'b0;
  logic          mem_we, frame_done, overflow, busy;
  logic [AW-1:0] mem_addr;
  logic [11:0]   mem_wdata;

  always #5 clk = ~clk;

  blur_frame_writer #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .FIFO_DEPTH (DEPTH),
    .ADDR_W     (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .le          (le),
    .i_data      (i_data),
    .mem_ready   (mem_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .frame_done  (frame_done),
    .overflow    (overflow),
    .busy        (busy)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: a pixel queue plus frame bookkeeping.
  bit          m_valid = 0;
  bit          m_active = 0;
  bit          m_done = 0;
  bit          m_ovf = 0;
  int          m_cnt = 0;
  int          m_addr = 0;
  logic [11:0] m_q[$];

  typedef struct {
    int          addr;
    logic [11:0] data;
  } wr_t;
  wr_t wlog[$];
  int  done_cnt = 0;
  bit  ovf_at_done = 0;

  typedef struct {
    bit          r, fs, l;
    logic [11:0] d;
    bit          rd;
    bit          e_we, e_busy, e_done, e_ovf;
    int          e_addr;
    logic [11:0] e_wdata;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: compare outputs with the model, drive the next
  // inputs, advance the model across the coming posedge.
  task automatic step(input bit r, input bit fs, input bit l, input logic [11:0] d, input bit rd);
    bit m_we, pop, was_empty, was_full;
    int old_addr, old_cnt;
    m_we = m_active && (m_q.size() > 0);
    if (m_valid) begin
      chk("we", mem_we, m_we);
      chk("addr", mem_addr, m_addr);
      chk("wdata", mem_wdata, m_we ? m_q[0] : 12'h000);
      chk("done", frame_done, m_done);
      chk("ovf", overflow, m_ovf);
      chk("busy", busy, m_active);
    end
    if (frame_done) begin
      done_cnt++;
      ovf_at_done = overflow;
    end
    reset = r; frame_start = fs; le = l; i_data = d; mem_ready = rd;
    if (mem_we && rd && r && !fs) wlog.push_back('{int'(mem_addr), mem_wdata});

    if (!r) begin
      m_active = 0; m_done = 0; m_ovf = 0; m_cnt = 0; m_addr = 0;
      m_q.delete();
      m_valid = 1;
    end else if (fs) begin
      m_active = 1; m_done = 0; m_ovf = 0; m_cnt = 0; m_addr = 0;
      m_q.delete();
    end else if (m_done) begin
      m_done = 0;
    end else if (m_active) begin
      pop = m_we && rd;
      old_addr = m_addr;
      old_cnt = m_cnt;
      was_empty = (m_q.size() == 0);
      was_full = (m_q.size() == DEPTH);
      if (pop) void'(m_q.pop_front());
      if (l && old_cnt < TOTAL) begin
        m_cnt++;
        if (!was_full || pop) m_q.push_back(d);
        else m_ovf = 1;
      end
      if (pop && old_addr == TOTAL - 1) begin
        m_active = 0; m_done = 1;
      end else if (pop) begin
        m_addr++;
      end else if (old_cnt == TOTAL && was_empty) begin
        m_active = 0; m_done = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic start_scn();
    wlog.delete();
    done_cnt = 0;
    ovf_at_done = 0;
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && done_cnt == 0; k++) step(1, 0, 1, 12'hFFF, 1);
    for (int k = 0; k < 3; k++) step(1, 0, 0, 12'h000, 1);
  endtask

  task automatic check_log(input string tag, input int n, input logic [11:0] base, input bit exp_ovf);
    chk({tag, "_len"}, wlog.size(), n);
    for (int i = 0; i < n && i < wlog.size(); i++) begin
      chk({tag, "_waddr"}, wlog[i].addr, i);
      chk({tag, "_wdata"}, wlog[i].data, base + 12'(i));
    end
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_ovf"}, ovf_at_done, exp_ovf);
  endtask

  task automatic full_frame(input string tag, input logic [11:0] base);
    start_scn();
    step(1, 1, 0, 12'h000, 1);
    for (int i = 0; i < TOTAL; i++) step(1, 0, 1, base + 12'(i), 1);
    drain(30);
    check_log(tag, TOTAL, base, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          r  fs l  d       rd we busy done ovf addr wdata
    vecs[0] = '{0, 0, 0, 12'h000, 0, 0, 0, 0, 0, 0, 12'h000};
    vecs[1] = '{1, 0, 1, 12'h5A5, 1, 0, 0, 0, 0, 0, 12'h000};
    vecs[2] = '{1, 0, 1, 12'h5A6, 1, 0, 0, 0, 0, 0, 12'h000};
    vecs[3] = '{1, 1, 1, 12'h777, 1, 0, 1, 0, 0, 0, 12'h000};
    vecs[4] = '{1, 0, 1, 12'h000, 1, 1, 1, 0, 0, 0, 12'h000};
    vecs[5] = '{1, 0, 1, 12'h001, 1, 1, 1, 0, 0, 1, 12'h001};
    vecs[6] = '{1, 0, 1, 12'h002, 0, 1, 1, 0, 0, 1, 12'h001};
    vecs[7] = '{1, 0, 0, 12'h000, 1, 1, 1, 0, 0, 2, 12'h002};
    vecs[8] = '{1, 0, 0, 12'h000, 1, 0, 1, 0, 0, 3, 12'h000};
    vecs[9] = '{1, 1, 0, 12'h000, 1, 0, 1, 0, 0, 0, 12'h000};

    @(negedge clk);
    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].fs, vecs[i].l, vecs[i].d, vecs[i].rd);
      chk("tbl_we", mem_we, vecs[i].e_we);
      chk("tbl_busy", busy, vecs[i].e_busy);
      chk("tbl_done", frame_done, vecs[i].e_done);
      chk("tbl_ovf", overflow, vecs[i].e_ovf);
      chk("tbl_addr", mem_addr, vecs[i].e_addr);
      chk("tbl_wdata", mem_wdata, vecs[i].e_wdata);
    end
    for (int k = 0; k < 3; k++) step(1, 0, 0, 12'h000, 1);

    // Straight frame at full throughput; trailing le beyond TOTAL ignored.
    full_frame("basic", 12'h000);

    // Long backpressure: FIFO fills, four pixels dropped, hole exit.
    start_scn();
    step(1, 1, 0, 12'h000, 1);
    for (int i = 0; i < TOTAL; i++) step(1, 0, 1, 12'(i), 0);
    for (int k = 0; k < 7; k++) step(1, 0, 0, 12'h000, 0);
    drain(30);
    check_log("stall", DEPTH, 12'h000, 1);

    // Ready toggling every cycle, pixels every other cycle.
    start_scn();
    step(1, 1, 0, 12'h000, 1);
    for (int i = 0; i < TOTAL; i++) begin
      step(1, 0, 1, 12'h040 + 12'(i), 0);
      step(1, 0, 0, 12'h000, 1);
    end
    drain(30);
    check_log("toggle", TOTAL, 12'h040, 0);

    // Abort after five buffered pixels.
    start_scn();
    step(1, 1, 0, 12'h000, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 1, 12'h100 + 12'(i), 0);
    step(1, 1, 0, 12'h000, 0);
    chk("abort_we", mem_we, 0);
    chk("abort_addr", mem_addr, 0);
    chk("abort_no_done", done_cnt, 0);
    for (int i = 0; i < TOTAL; i++) step(1, 0, 1, 12'h200 + 12'(i), 1);
    drain(30);
    check_log("abort", TOTAL, 12'h200, 0);

    // Reset in the middle of the write at address 6.
    start_scn();
    step(1, 1, 0, 12'h000, 1);
    for (int i = 0; i < TOTAL; i++) begin
      if (m_addr == 6 && m_q.size() > 0) break;
      step(1, 0, 1, 12'h300 + 12'(i), 1);
    end
    chk("midrst_pre_addr", mem_addr, 6);
    step(0, 0, 1, 12'h3FF, 1);
    chk("midrst_we", mem_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_addr", mem_addr, 0);
    chk("midrst_wdata", mem_wdata, 0);
    step(1, 0, 1, 12'h3FE, 1);
    chk("midrst_idle", busy, 0);
    full_frame("after_rst", 12'h400);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      bit r, fs, l, rd;
      r  = ($urandom_range(0, 199) != 0);
      fs = ($urandom_range(0, 79) == 0) || (!m_active && !m_done && $urandom_range(0, 3) == 0);
      l  = ($urandom_range(0, 9) < 7);
      rd = ($urandom_range(0, 9) < 6);
      step(r, fs, l, 12'($urandom), rd);
    end
    step(1, 0, 0, 12'h000, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
